alu_op_sequencer: RTL

- Sequences operations onto the shared combinational 32-bit ALU (ports operandA, operandB, command; flags carryout, zero, overflow).
- Arbitrates between two requesters using round-robin.
- Holds operands stable for a fixed settle time, because the gate-level ALU has long propagation delay.
- Captures the result and flags, then returns them with a valid/ready handshake.

---
 rtl/alu_op_sequencer_if.sv | 69 ++++++
 rtl/alu_op_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_sequencer_if                                                        |
// | Requester, response and ALU-side bundle of alu_op_sequencer.               |
// | Macro ALU_SEQ_STATS_EN adds the per-requester retire counters.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface alu_op_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [2:0]       req0_cmd;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [2:0]       req1_cmd;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_carryout;
   logic             rsp_zero;
   logic             rsp_overflow;
   logic [WIDTH-1:0] alu_operandA;
   logic [WIDTH-1:0] alu_operandB;
   logic [2:0]       alu_command;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carryout;
   logic             alu_zero;
   logic             alu_overflow;
   logic             busy;
`ifdef ALU_SEQ_STATS_EN
   logic [15:0]      op_count0;
   logic [15:0]      op_count1;
`endif

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cmd,
      input  req1_valid, req1_a, req1_b, req1_cmd,
      input  rsp_ready,
      input  alu_result, alu_carryout, alu_zero, alu_overflow,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow,
      output alu_operandA, alu_operandB, alu_command,
`ifdef ALU_SEQ_STATS_EN
      output op_count0, op_count1,
`endif
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_cmd,
      output req1_valid, req1_a, req1_b, req1_cmd,
      output rsp_ready,
      output alu_result, alu_carryout, alu_zero, alu_overflow,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow,
      input  alu_operandA, alu_operandB, alu_command,
`ifdef ALU_SEQ_STATS_EN
      input  op_count0, op_count1,
`endif
      input  busy
   );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_sequencer                                                           |
// | Round-robin sequencer holding operands on a slow ALU for SETTLE_CYCLES.    |
// | Macro ALU_SEQ_STATS_EN adds 16-bit per-requester retire counters.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_op_sequencer #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   alu_op_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [7:0] c_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t           r_state;
   logic             r_last_grant;
   logic [7:0]       r_cnt;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_result;
   logic             r_rsp_carryout;
   logic             r_rsp_zero;
   logic             r_rsp_overflow;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [2:0]       r_alu_cmd;

   logic w_idle;
   logic w_ready0;
   logic w_ready1;

   // last_grant==1 means requester 0 has priority on the next contention
   assign w_idle   = (r_state == S_IDLE);
   assign w_ready0 = w_idle && bus.req0_valid && (!bus.req1_valid ||  r_last_grant);
   assign w_ready1 = w_idle && bus.req1_valid && (!bus.req0_valid || !r_last_grant);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_last_grant   <= 1'b1;
         r_cnt          <= 8'd0;
         r_rsp_valid    <= 1'b0;
         r_rsp_id       <= 1'b0;
         r_rsp_result   <= '0;
         r_rsp_carryout <= 1'b0;
         r_rsp_zero     <= 1'b0;
         r_rsp_overflow <= 1'b0;
         r_alu_a        <= '0;
         r_alu_b        <= '0;
         r_alu_cmd      <= 3'b000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_ready0) begin
                  r_alu_a      <= bus.req0_a;
                  r_alu_b      <= bus.req0_b;
                  r_alu_cmd    <= bus.req0_cmd;
                  r_rsp_id     <= 1'b0;
                  r_last_grant <= 1'b0;
                  r_cnt        <= c_SETTLE_LOAD;
                  r_state      <= S_SETTLE;
               end else if (w_ready1) begin
                  r_alu_a      <= bus.req1_a;
                  r_alu_b      <= bus.req1_b;
                  r_alu_cmd    <= bus.req1_cmd;
                  r_rsp_id     <= 1'b1;
                  r_last_grant <= 1'b1;
                  r_cnt        <= c_SETTLE_LOAD;
                  r_state      <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (r_cnt == 8'd0) begin
                  r_rsp_result   <= bus.alu_result;
                  r_rsp_carryout <= bus.alu_carryout;
                  r_rsp_zero     <= bus.alu_zero;
                  r_rsp_overflow <= bus.alu_overflow;
                  r_rsp_valid    <= 1'b1;
                  r_state        <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_STATS_EN
   logic [15:0] r_op_count0;
   logic [15:0] r_op_count1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op_count0 <= 16'd0;
         r_op_count1 <= 16'd0;
      end else if (r_rsp_valid && bus.rsp_ready) begin
         if (r_rsp_id) r_op_count1 <= r_op_count1 + 16'd1;
         else          r_op_count0 <= r_op_count0 + 16'd1;
      end
   end

   assign bus.op_count0 = r_op_count0;
   assign bus.op_count1 = r_op_count1;
`endif

   assign bus.req0_ready   = w_ready0;
   assign bus.req1_ready   = w_ready1;
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_id       = r_rsp_id;
   assign bus.rsp_result   = r_rsp_result;
   assign bus.rsp_carryout = r_rsp_carryout;
   assign bus.rsp_zero     = r_rsp_zero;
   assign bus.rsp_overflow = r_rsp_overflow;
   assign bus.alu_operandA = r_alu_a;
   assign bus.alu_operandB = r_alu_b;
   assign bus.alu_command  = r_alu_cmd;
   assign bus.busy         = !w_idle;
endmodule
`default_nettype wire
